pixel_combinator: RTL

PIXEL_COMBINATOR -- requirements
Module: pixel_combinator

---
 rtl/pixel_combinator_pkg.sv | 26 ++
 rtl/pixel_combinator_if.sv | 26 ++
 rtl/pixel_out_reg.sv | 60 ++++++
 rtl/pixel_combinator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pixel_combinator_pkg.sv
// Shared types and constants for the pixel combinator and the reorder queues
// that feed it: FSM state encoding, the "no request" coordinate sentinel and
// the default frame geometry.
package pixel_combinator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EMIT = 2'd2
    } pc_state_e;

    localparam int DEF_X_SIZE      = 640;
    localparam int DEF_Y_SIZE      = 480;
    localparam int DEF_TIMEOUT     = 4096;

    // Coordinates carrying all ones never match a queued pixel, so queues
    // ignore the request bus while it holds this value.
    localparam int                         MAX_COORD_WIDTH = 64;
    localparam logic [MAX_COORD_WIDTH-1:0] COORD_SENTINEL  = {MAX_COORD_WIDTH{1'b1}};

    // True when more than one bit of the vector is set.
    function automatic logic more_than_one(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/pixel_combinator_if.sv
// Valid/ready pixel output stream with start-of-frame and end-of-line marks.
interface pixel_combinator_if #(
    parameter int RBG_SIZE = 24
);
    logic [RBG_SIZE-1:0] pixel_data;
    logic                pixel_valid;
    logic                pixel_ready;
    logic                sof;
    logic                eol;

    modport master (
        output pixel_data,
        output pixel_valid,
        output sof,
        output eol,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        input  sof,
        input  eol,
        output pixel_ready
    );
endinterface

// File: rtl/pixel_out_reg.sv
// Output holding register: captures a pixel with its frame marks and keeps
// everything stable until the consumer takes it.
module pixel_out_reg
    import pixel_combinator_pkg::*;
#(
    parameter int RBG_SIZE = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [RBG_SIZE-1:0] data_i,
    input  logic                sof_i,
    input  logic                eol_i,
    pixel_combinator_if.master  pix
);

    logic [RBG_SIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                sof_q, sof_d;
    logic                eol_q, eol_d;

    // Load a new pixel, drop valid once it is accepted, otherwise hold
    always_comb begin
        data_d  = data_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            sof_d   = sof_i;
            eol_d   = eol_i;
            valid_d = 1'b1;
        end else if (valid_q && pix.pixel_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output flops with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= {RBG_SIZE{1'b0}};
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            valid_q <= valid_d;
        end
    end

    assign pix.pixel_data  = data_q;
    assign pix.pixel_valid = valid_q;
    assign pix.sof         = sof_q;
    assign pix.eol         = eol_q;

endmodule

// File: rtl/pixel_combinator.sv
// Raster-order pixel gatherer: broadcasts each (x,y) to the reorder queues,
// takes the colour from whichever queue reports a hit, and streams the
// pixels out over valid/ready, one frame per start pulse.
module pixel_combinator
    import pixel_combinator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RBG_SIZE   = 24,
    parameter int NUM_QUEUES = 4,
    parameter int X_SIZE     = DEF_X_SIZE,
    parameter int Y_SIZE     = DEF_Y_SIZE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
    input  logic [NUM_QUEUES-1:0]          hit_i,
    output logic [DATA_WIDTH-1:0]          xpixel_check,
    output logic [DATA_WIDTH-1:0]          ypixel_check,
    pixel_combinator_if.master             pix,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           stall_err,
    output logic                           multi_hit_err
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

    pc_state_e           state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                stall_err_q, stall_err_d;
    logic                multi_hit_err_q, multi_hit_err_d;

    logic [RBG_SIZE-1:0] sel_colour_s;
    logic                hit_any_s;
    logic                multi_hot_s;
    logic                load_s;
    logic                sof_s;
    logic                eol_s;

    // Lowest-indexed hitting queue supplies the colour
    always_comb begin
        sel_colour_s = {RBG_SIZE{1'b0}};
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            sel_colour_s = hit_i[k] ? colour_i[k*RBG_SIZE +: RBG_SIZE] : sel_colour_s;
        end
    end

    assign hit_any_s   = |hit_i;
    assign multi_hot_s = more_than_one(64'(hit_i));
    assign load_s      = (state_q == ST_REQ) && hit_any_s;
    assign sof_s       = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
    assign eol_s       = (x_q == X_LAST);

    // Broadcast the raster coordinate only while a request is outstanding
    always_comb begin
        if (state_q == ST_REQ) begin
            xpixel_check = DATA_WIDTH'(x_q);
            ypixel_check = DATA_WIDTH'(y_q);
        end else begin
            xpixel_check = COORD_SENTINEL[DATA_WIDTH-1:0];
            ypixel_check = COORD_SENTINEL[DATA_WIDTH-1:0];
        end
    end

    // Next-state logic: raster walk, wait timer and sticky error flags
    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        wait_d          = wait_q;
        frame_done_d    = 1'b0;
        stall_err_d     = stall_err_q;
        multi_hit_err_d = multi_hit_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                    wait_d  = {WW{1'b0}};
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (hit_any_s) begin
                    multi_hit_err_d = multi_hit_err_q | multi_hot_s;
                    state_d         = ST_EMIT;
                end else begin
                    // Saturate so the timeout flag cannot be missed by wrap
                    wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + WW'(1);
                    stall_err_d = stall_err_q | (wait_d == WAIT_MAX);
                end
            end
            ST_EMIT: begin
                if (pix.pixel_ready) begin
                    wait_d = {WW{1'b0}};
                    if (x_q == X_LAST) begin
                        x_d = {XW{1'b0}};
                        if (y_q == Y_LAST) begin
                            y_d          = {YW{1'b0}};
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            y_d     = y_q + YW'(1);
                            state_d = ST_REQ;
                        end
                    end else begin
                        x_d     = x_q + XW'(1);
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and status flops with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            x_q             <= {XW{1'b0}};
            y_q             <= {YW{1'b0}};
            wait_q          <= {WW{1'b0}};
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
            stall_err_q     <= 1'b0;
            multi_hit_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            wait_q          <= wait_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= busy_d;
            stall_err_q     <= stall_err_d;
            multi_hit_err_q <= multi_hit_err_d;
        end
    end

    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
    assign stall_err     = stall_err_q;
    assign multi_hit_err = multi_hit_err_q;

    pixel_out_reg #(
        .RBG_SIZE (RBG_SIZE)
    ) u_out (
        .clk    (clk),
        .reset  (reset),
        .load_i (load_s),
        .data_i (sel_colour_s),
        .sof_i  (sof_s),
        .eol_i  (eol_s),
        .pix    (pix)
    );

endmodule
